// File: rtl/rx_accept_ctrl.sv
// Receive acceptance controller: captures the frame identifier, scans the
// acceptance filters one per clock and hands accepted frames to the receive buffer.
module rx_accept_ctrl #(
    parameter int NFILT  = 4,
    parameter int FIDX_W = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rx_done,
    input  logic [17:0]           message_b,
    input  logic [10:0]           message_c,
    input  logic                  extended,
    input  logic [NFILT-1:0]      filt_en,
    input  logic [NFILT-1:0]      filt_ide,
    input  logic [29*NFILT-1:0]   filt_id,
    input  logic [29*NFILT-1:0]   filt_mask,
    output logic                  wr_req,
    input  logic                  wr_ack,
    output logic [28:0]           wr_id,
    output logic                  wr_ide,
    output logic [FIDX_W-1:0]     wr_fidx,
    output logic                  acc_pulse,
    output logic                  rej_pulse,
    output logic                  ovr_pulse,
    output logic                  busy,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [28:0]           r_id;
    logic                  r_ide;
    logic [FIDX_W-1:0]     r_idx;
    logic [FIDX_W-1:0]     r_fidx;
    logic                  r_acc;
    logic                  r_rej;
    logic                  r_ovr;

    logic [28:0]           w_id;
    logic [NFILT-1:0]      w_hit_vec;
    logic [2**FIDX_W-1:0]  w_hit_ext;
    logic                  w_hit;
    logic                  w_last;
    logic                  w_load;
    logic                  w_take_hit;
    logic                  w_acc;
    logic                  w_rej;
    logic                  w_ovr;

    // Basic frames carry their 11-bit ID in message_b[10:0], placed at the top of the 29-bit ID.
    always_comb begin
        w_id = extended ? {message_c, message_b} : {message_b[10:0], 18'd0};
    end

    always_comb begin
        w_hit_vec = '0;
        for (int k = 0; k < NFILT; k++) begin
            w_hit_vec[k] = filt_en[k] & (filt_ide[k] == r_ide) &
                           (((r_id ^ filt_id[29*k +: 29]) & filt_mask[29*k +: 29]) == 29'd0);
        end
        w_hit_ext = '0;
        w_hit_ext[NFILT-1:0] = w_hit_vec;
    end

    assign w_hit  = w_hit_ext[r_idx];
    assign w_last = (r_idx == FIDX_W'(NFILT - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_take_hit = 1'b0;
        w_acc      = 1'b0;
        w_rej      = 1'b0;
        w_ovr      = rx_done & (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (rx_done) begin
                    w_load = 1'b1;
                    w_next = (filt_en == '0) ? ST_WRITE : ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (w_hit) begin
                    w_take_hit = 1'b1;
                    w_next     = ST_WRITE;
                end else if (w_last) begin
                    w_rej  = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (wr_ack) begin
                    w_acc  = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Frame data only loads in IDLE, so wr_id/wr_ide stay stable for the whole write.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_id   <= '0;
            r_ide  <= 1'b0;
            r_idx  <= '0;
            r_fidx <= '0;
            r_acc  <= 1'b0;
            r_rej  <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            r_acc <= w_acc;
            r_rej <= w_rej;
            r_ovr <= w_ovr;
            if (w_load) begin
                r_id   <= w_id;
                r_ide  <= extended;
                r_idx  <= '0;
                r_fidx <= '0;
            end else if (r_state == ST_SCAN && !w_hit && !w_last) begin
                r_idx <= r_idx + FIDX_W'(1);
            end
            if (w_take_hit) begin
                r_fidx <= r_idx;
            end
        end
    end

    assign wr_req    = (r_state == ST_WRITE);
    assign wr_id     = r_id;
    assign wr_ide    = r_ide;
    assign wr_fidx   = r_fidx;
    assign acc_pulse = r_acc;
    assign rej_pulse = r_rej;
    assign ovr_pulse = r_ovr;
    assign busy      = (r_state != ST_IDLE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_rx_accept_ctrl.sv
// Self-checking bench for rx_accept_ctrl: directed latency/pulse checks plus a
// scoreboard of expected buffer writes compared at each acknowledged write.
module tb_rx_accept_ctrl;
  localparam int NFILT  = 4;
  localparam int FIDX_W = 2;
  localparam int W      = 1 + FIDX_W + 29;

  // clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                rx_done = 1'b0;
  logic [17:0]         message_b = '0;
  logic [10:0]         message_c = '0;
  logic                extended = 1'b0;
  logic [NFILT-1:0]    filt_en = '0;
  logic [NFILT-1:0]    filt_ide = '0;
  logic [29*NFILT-1:0] filt_id = '0;
  logic [29*NFILT-1:0] filt_mask = '0;
  logic                wr_ack = 1'b0;
  logic                wr_req;
  logic [28:0]         wr_id;
  logic                wr_ide;
  logic [FIDX_W-1:0]   wr_fidx;
  logic                acc_pulse;
  logic                rej_pulse;
  logic                ovr_pulse;
  logic                busy;
  logic [1:0]          dbg_state;

  rx_accept_ctrl #(.NFILT(NFILT), .FIDX_W(FIDX_W)) dut (
    .clock(clk), .reset(rst), .rx_done(rx_done), .message_b(message_b),
    .message_c(message_c), .extended(extended), .filt_en(filt_en),
    .filt_ide(filt_ide), .filt_id(filt_id), .filt_mask(filt_mask),
    .wr_req(wr_req), .wr_ack(wr_ack), .wr_id(wr_id), .wr_ide(wr_ide),
    .wr_fidx(wr_fidx), .acc_pulse(acc_pulse), .rej_pulse(rej_pulse),
    .ovr_pulse(ovr_pulse), .busy(busy), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // scoreboard: every acknowledged write must match the oldest expected write
  always @(negedge clk) begin
    if (!rst && wr_req && wr_ack) begin
      if (exp_q.size() == 0) check("unexpected_wr", 1, 0);
      else check("wr_data", {wr_ide, wr_fidx, wr_id}, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_filter(input int k, input logic en, input logic ide,
                            input logic [28:0] id, input logic [28:0] mask);
    filt_en[k]            = en;
    filt_ide[k]           = ide;
    filt_id[29*k +: 29]   = id;
    filt_mask[29*k +: 29] = mask;
  endtask

  task automatic clear_filters();
    for (int k = 0; k < NFILT; k++) set_filter(k, 1'b0, 1'b0, 29'd0, 29'd0);
  endtask

  task automatic send_frame(input logic [17:0] b, input logic [10:0] c, input logic ext);
    message_b = b;
    message_c = c;
    extended  = ext;
    rx_done   = 1'b1;
    tick();
    rx_done   = 1'b0;
  endtask

  // lat counts cycles after rx_done until wr_req or rej_pulse is seen
  task automatic wait_result(output int lat, output logic rej);
    lat = 1;
    while (!wr_req && !rej_pulse && lat < 40) begin
      tick();
      lat++;
    end
    rej = rej_pulse;
    if (!wr_req && !rej_pulse) check("wait_timeout", 0, 1);
  endtask

  task automatic ack_write();
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    check("acc_pulse", acc_pulse, 1);
    check("req_drop", wr_req, 0);
  endtask

  function automatic logic [28:0] model_id(input logic [17:0] b, input logic [10:0] c, input logic ext);
    return ext ? {c, b} : {b[10:0], 18'd0};
  endfunction

  // returns {hit, index}; accept-all when no filter is enabled
  function automatic logic [FIDX_W:0] model_match(input logic [28:0] id, input logic ide);
    if (filt_en == '0) return {1'b1, {FIDX_W{1'b0}}};
    for (int k = 0; k < NFILT; k++) begin
      if (filt_en[k] && filt_ide[k] == ide &&
          ((id & filt_mask[29*k +: 29]) == (filt_id[29*k +: 29] & filt_mask[29*k +: 29])))
        return {1'b1, FIDX_W'(k)};
    end
    return '0;
  endfunction

  int   lat;
  logic rej;
  logic [28:0] a_id;

  initial begin
    // reset state
    repeat (3) tick();
    rst = 1'b0;
    check("reset_outs", {wr_req, wr_id, wr_ide, wr_fidx, acc_pulse, rej_pulse, ovr_pulse, busy}, 0);

    // basic frame, filter 0; junk in message_b[17:11] must be ignored
    clear_filters();
    set_filter(0, 1'b1, 1'b0, 29'h048C0000, 29'h1FFC0000);
    exp_q.push_back({1'b0, 2'd0, 29'h048C0000});
    send_frame(18'h2A123, 11'h000, 1'b0);
    wait_result(lat, rej);
    check("basic_lat", lat, 2);
    check("basic_id", wr_id, 29'h048C0000);
    check("basic_fidx", wr_fidx, 0);
    ack_write();

    // extended frame, only filter 3 matches (filter 0 differs only in format)
    set_filter(0, 1'b1, 1'b0, 29'h1FFFFFFF, 29'h1FFFFFFF);
    set_filter(1, 1'b1, 1'b1, 29'h00000000, 29'h00000001);
    set_filter(2, 1'b1, 1'b1, 29'h00000000, 29'h10000000);
    set_filter(3, 1'b1, 1'b1, 29'h1FFFFFFF, 29'h1FFFFFFF);
    exp_q.push_back({1'b1, 2'd3, 29'h1FFFFFFF});
    send_frame(18'h3FFFF, 11'h7FF, 1'b1);
    wait_result(lat, rej);
    check("ext_lat", lat, 5);
    check("ext_id", wr_id, 29'h1FFFFFFF);
    check("ext_ide", wr_ide, 1);
    check("ext_fidx", wr_fidx, 3);
    ack_write();

    // lowest matching index wins
    set_filter(1, 1'b1, 1'b1, 29'h1FFFFFFF, 29'h00000FFF);
    set_filter(2, 1'b1, 1'b1, 29'h1FFFFFFF, 29'h00000FFF);
    exp_q.push_back({1'b1, 2'd1, 29'h1FFFFFFF});
    send_frame(18'h3FFFF, 11'h7FF, 1'b1);
    wait_result(lat, rej);
    check("prio_lat", lat, 3);
    check("prio_fidx", wr_fidx, 1);
    ack_write();

    // no match with filters 2,3 disabled: still four scan cycles
    filt_en = 4'b0011;
    send_frame(18'h00123, 11'h000, 1'b0);
    wait_result(lat, rej);
    check("rej_lat", lat, 5);
    check("rej_flag", rej, 1);
    check("rej_busy", busy, 0);
    check("rej_no_req", wr_req, 0);

    // accept-all frame in the cycle right after rej_pulse, then a long stall
    filt_en = '0;
    exp_q.push_back({1'b0, 2'd0, model_id(18'h00555, 11'h0, 1'b0)});
    send_frame(18'h00555, 11'h000, 1'b0);
    check("aa_req", wr_req, 1);
    check("aa_fidx", wr_fidx, 0);
    a_id = wr_id;
    check("aa_id", a_id, model_id(18'h00555, 11'h0, 1'b0));
    for (int i = 0; i < 10; i++) begin
      tick();
      check("aa_hold", {wr_req, wr_id}, {1'b1, a_id});
    end
    ack_write();

    // overrun during write and in the ack cycle
    exp_q.push_back({1'b1, 2'd0, model_id(18'h0ABCD, 11'h321, 1'b1)});
    send_frame(18'h0ABCD, 11'h321, 1'b1);
    send_frame(18'h11111, 11'h111, 1'b1);
    check("ovr1_pulse", ovr_pulse, 1);
    check("ovr1_keep", wr_id, model_id(18'h0ABCD, 11'h321, 1'b1));
    rx_done = 1'b1;
    wr_ack  = 1'b1;
    tick();
    rx_done = 1'b0;
    wr_ack  = 1'b0;
    check("ovr2_pulses", {acc_pulse, ovr_pulse, wr_req}, 3'b110);
    tick();
    check("ovr_idle", {busy, ovr_pulse, acc_pulse}, 0);
    repeat (3) tick();
    check("ovr_no_write", wr_req, 0);

    // reset mid-scan at T+2
    clear_filters();
    filt_en = 4'b1111;
    send_frame(18'h00321, 11'h000, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_outs", {wr_req, wr_id, wr_ide, wr_fidx, acc_pulse, rej_pulse, ovr_pulse, busy}, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_no_pulse", {acc_pulse, rej_pulse, ovr_pulse, busy}, 0);
    end
    set_filter(0, 1'b1, 1'b0, 29'h0C840000, 29'h1FFC0000);
    exp_q.push_back({1'b0, 2'd0, 29'h0C840000});
    send_frame(18'h00321, 11'h000, 1'b0);
    wait_result(lat, rej);
    check("rst_next_lat", lat, 2);
    ack_write();

    // randomised frames against the reference model
    for (int it = 0; it < 10; it++) begin
      logic [31:0]       rb, rc;
      logic [17:0]       b;
      logic [10:0]       c;
      logic              ext;
      logic [28:0]       fid, fmask;
      logic [FIDX_W:0]   m;
      rb  = $urandom();
      rc  = $urandom();
      b   = rb[17:0];
      c   = rc[10:0];
      ext = 1'($urandom_range(0, 1));
      for (int k = 0; k < NFILT; k++) begin
        rb    = $urandom();
        fmask = rb[28:0];
        fid   = model_id(b, c, ext) ^ (29'd1 << $urandom_range(0, 28));
        set_filter(k, 1'($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0) ? ~ext : ext, fid, fmask);
      end
      m = model_match(model_id(b, c, ext), ext);
      if (m[FIDX_W]) exp_q.push_back({ext, m[FIDX_W-1:0], model_id(b, c, ext)});
      send_frame(b, c, ext);
      wait_result(lat, rej);
      if (m[FIDX_W]) begin
        check("rnd_lat", lat, (filt_en == '0) ? 1 : 2 + int'(m[FIDX_W-1:0]));
        check("rnd_rej", rej, 0);
        repeat ($urandom_range(0, 3)) tick();
        ack_write();
      end else begin
        check("rnd_lat", lat, NFILT + 1);
        check("rnd_rej", rej, 1);
      end
      tick();
    end

    check("exp_q_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
